// File: rtl/rv_isa_pkg.sv
// rtl/rv_isa_pkg.sv - RV32I format enum, opcode constants and immediate ranges
package rv_isa_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int IMM13_MIN = -4096;
   localparam int IMM13_MAX = 4094;
   localparam int IMM21_MIN = -(1 << 20);
   localparam int IMM21_MAX = (1 << 20) - 2;

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - scatter a signed immediate and fields into an RV32I word
import rv_isa_pkg::*;

module imm_pack (
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        legal
);

   logic signed [31:0] simm;

   always_comb begin
      simm  = imm;
      word  = '0;
      legal = 1'b0;
      case (fmt)
         FMT_R: begin
            word  = {funct7, rs2, rs1, funct3, rd, opcode};
            legal = 1'b1;
         end
         FMT_I: begin
            word  = {imm[11:0], rs1, funct3, rd, opcode};
            legal = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
         end
         FMT_S: begin
            word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            legal = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
         end
         FMT_B: begin
            word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            legal = (simm >= IMM13_MIN) && (simm <= IMM13_MAX) && !imm[0];
         end
         FMT_U: begin
            word  = {imm[31:12], rd, opcode};
            legal = (imm[11:0] == 12'd0);
         end
         FMT_J: begin
            word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            legal = (simm >= IMM21_MIN) && (simm <= IMM21_MAX) && !imm[0];
         end
         default: begin
            word  = '0;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - handshake, output register and address counter for the program loader
import rv_isa_pkg::*;

module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              err_q, err_d;
   logic [31:0]       packed_word;
   logic              packed_legal;
   logic              accept, complete;

   imm_pack u_imm_pack (
      .fmt    (in_fmt),
      .opcode (in_opcode),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .funct3 (in_funct3),
      .funct7 (in_funct7),
      .imm    (in_imm),
      .word   (packed_word),
      .legal  (packed_legal)
   );

   // count reaching 2^ADDR_W is exactly the MSB of the counter
   assign full     = count_q[ADDR_W];
   assign in_ready = rst_n && !start && !full && (!mem_we_q || mem_ready);
   assign accept   = in_valid && in_ready;
   assign complete = mem_we_q && mem_ready;

   always_comb begin
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      count_d     = count_q;
      err_d       = err_q;
      if (start) begin
         mem_we_d   = 1'b0;
         mem_addr_d = BASE;
         count_d    = '0;
         err_d      = 1'b0;
      end else begin
         if (complete) begin
            count_d  = count_q + (ADDR_W+1)'(1);
            mem_we_d = 1'b0;
         end
         // address uses the post-completion count so back-to-back words stay contiguous
         if (accept) begin
            if (packed_legal) begin
               mem_we_d    = 1'b1;
               mem_wdata_d = packed_word;
               mem_addr_d  = BASE + count_d[ADDR_W-1:0];
            end else begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= BASE;
         mem_wdata_q <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         count_q     <= count_d;
         err_q       <= err_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign count     = count_q;
   assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with a 4-word memory
module tb_instr_encoder;

   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_fmt = '0;
   logic [6:0]    in_opcode = '0;
   logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]    in_funct3 = '0;
   logic [6:0]    in_funct7 = '0;
   logic [31:0]   in_imm = '0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ready = 1'b1;
   logic [AW:0]   count;
   logic          full;
   logic          err;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } exp_t;

   exp_t          sb[$];
   logic [AW-1:0] next_addr = '0;
   int            tests = 0;
   int            fails = 0;

   instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .count(count), .full(full), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && mem_we && mem_ready) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL write_unexpected: addr=%0d data=%h, none expected", mem_addr, mem_wdata);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
               fails++;
               $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] word,
                       input bit legal, output int waits);
      bit acc = 0;
      exp_t e;
      waits = 0;
      in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1;
            if (legal) begin
               e.addr = next_addr; e.data = word;
               sb.push_back(e);
               next_addr++;
            end
         end else begin
            waits++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      tests++;
      if (!acc) begin
         fails++;
         $display("FAIL accept_timeout: in_ready never 1, expected acceptance");
      end else if (mem_we !== legal) begin
         fails++;
         $display("FAIL write_latency: mem_we=%b one cycle after accept, expected %b", mem_we, legal);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL start_ready: in_ready=%b during start, expected 0", in_ready);
      end
      @(posedge clk); #1;
      start = 1'b0;
      sb.delete();
      next_addr = '0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (in_ready !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0 ||
          count !== 0 || full !== 0 || err !== 0) begin
         fails++;
         $display("FAIL reset_state: rdy=%b we=%b addr=%0d wd=%h cnt=%0d full=%b err=%b, expected all 0",
                  in_ready, mem_we, mem_addr, mem_wdata, count, full, err);
      end
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", 32'(in_ready), 32'd1);
   endtask

   task automatic test_legal_iu();
      int w;
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1, w);
      send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1, w);
      @(posedge clk); #1;
      chk("count_after_iu", 32'(count), 32'd2);
   endtask

   task automatic test_s_b_full();
      int w;
      send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1, w);
      send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1, w);
      @(posedge clk); #1;
      chk("count_full", 32'(count), 32'd4);
      chk("full_flag", 32'(full), 32'd1);
      chk("ready_when_full", 32'(in_ready), 32'd0);
      do_start();
      chk("count_after_start", 32'(count), 32'd0);
      chk("full_after_start", 32'(full), 32'd0);
   endtask

   task automatic test_illegal();
      int w;
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'd0, 0, w);
      chk("err_i_2048", 32'(err), 32'd1);
      chk("count_i_2048", 32'(count), 32'd0);
      send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'd0, 0, w);
      send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'd0, 0, w);
      send(3'd6, 7'h33, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 0, w);
      chk("count_after_illegal", 32'(count), 32'd0);
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1, w);
      send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E000FE3, 1, w);
      @(posedge clk); #1;
      chk("count_after_legal", 32'(count), 32'd2);
      chk("err_sticky", 32'(err), 32'd1);
   endtask

   task automatic test_backpressure();
      int w;
      mem_ready = 1'b0;
      send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00113, 1, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (mem_we !== 1 || mem_addr !== 2'd2 || mem_wdata !== 32'hFFF00113 || in_ready !== 0) begin
            fails++;
            $display("FAIL stall_hold: we=%b addr=%0d wd=%h rdy=%b, expected 1/2/fff00113/0",
                     mem_we, mem_addr, mem_wdata, in_ready);
         end
      end
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      chk("count_after_release", 32'(count), 32'd3);
      chk("we_after_release", 32'(mem_we), 32'd0);
   endtask

   task automatic test_back_to_back();
      int w;
      do_start();
      chk("err_cleared", 32'(err), 32'd0);
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1, w);
      send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF, 1, w);
      chk("b2b_wait_1", 32'(w), 32'd0);
      send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 32'h8000006F, 1, w);
      chk("b2b_wait_2", 32'(w), 32'd0);
      send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000013, 1, w);
      chk("b2b_wait_3", 32'(w), 32'd0);
      @(posedge clk); #1;
      chk("b2b_count", 32'(count), 32'd4);
      chk("b2b_full", 32'(full), 32'd1);
      chk("b2b_ready", 32'(in_ready), 32'd0);
      do_start();
      send(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000, 32'hFFFFF037, 1, w);
      @(posedge clk); #1;
      chk("restart_count", 32'(count), 32'd1);
   endtask

   task automatic test_start_stall();
      int w;
      mem_ready = 1'b0;
      send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100213, 1, w);
      @(posedge clk); #1;
      do_start();
      chk("drop_we", 32'(mem_we), 32'd0);
      chk("drop_count", 32'(count), 32'd0);
      mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("drop_count_later", 32'(count), 32'd0);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      test_reset();
      test_legal_iu();
      test_s_b_full();
      test_illegal();
      test_backpressure();
      test_back_to_back();
      test_start_stall();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
